// File: rtl/top_tx.sv
// UART-style serial transmitter.
// Frame = start bit (0), DATA_LENGTH data bits LSB first, optional parity bit,
// stop bit (1). TX_OUT and BUSY come straight from flops so the line is glitch-free.
// The FSM state always names the bit currently on the line.
module top_tx #(
  parameter int DATA_LENGTH = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [DATA_LENGTH-1:0] P_DATA,
  input  logic                   DATA_VALID,
  input  logic                   PAR_EN,
  input  logic                   PAR_TYP,
  output logic                   TX_OUT,
  output logic                   BUSY
);

  // A one-bit word still needs a counter flop, so the width never drops to zero.
  localparam int CNT_W = (DATA_LENGTH > 1) ? $clog2(DATA_LENGTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_LENGTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                 state_reg;
  logic [DATA_LENGTH-1:0] shift_reg;   // latched word, shifted right as bits go out
  logic [CNT_W-1:0]       cnt_reg;     // index of the data bit currently on the line
  logic                   par_en_reg;
  logic                   parity_reg;
  logic                   tx_reg;
  logic                   busy_reg;
  logic                   accept;

  // Requests are honoured only while idle; everything else ignores DATA_VALID.
  assign accept = (state_reg == IDLE) && DATA_VALID;

  // Parity generator: computed once from the accepted word so later input changes cannot disturb it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      parity_reg <= 1'b0;
    end else if (accept) begin
      parity_reg <= (^P_DATA) ^ PAR_TYP;
    end
  end

  // Control FSM, serializer and output mux; outputs are registered alongside the state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg  <= IDLE;
      shift_reg  <= '0;
      cnt_reg    <= '0;
      par_en_reg <= 1'b0;
      tx_reg     <= 1'b1;
      busy_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          tx_reg   <= 1'b1;
          busy_reg <= 1'b0;
          if (DATA_VALID) begin
            shift_reg  <= P_DATA;
            par_en_reg <= PAR_EN;
            cnt_reg    <= '0;
            tx_reg     <= 1'b0;
            busy_reg   <= 1'b1;
            state_reg  <= START;
          end
        end

        START: begin
          tx_reg    <= shift_reg[0];
          shift_reg <= shift_reg >> 1;
          cnt_reg   <= '0;
          state_reg <= DATA;
        end

        DATA: begin
          if (cnt_reg == LAST_BIT) begin
            if (par_en_reg) begin
              tx_reg    <= parity_reg;
              state_reg <= PARITY;
            end else begin
              tx_reg    <= 1'b1;
              state_reg <= STOP;
            end
          end else begin
            cnt_reg   <= cnt_reg + CNT_W'(1);
            tx_reg    <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
          end
        end

        PARITY: begin
          tx_reg    <= 1'b1;
          state_reg <= STOP;
        end

        STOP: begin
          tx_reg    <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          tx_reg    <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign TX_OUT = tx_reg;
  assign BUSY   = busy_reg;

endmodule

// File: tb/tb_top_tx.sv
// Self-checking bench for top_tx (DATA_LENGTH = 8).
// Expected line samples are queued when a request is driven and popped one per
// cycle at the falling edge, where TX_OUT and BUSY are compared.
module tb_top_tx;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] p_data;
  logic         data_valid;
  logic         par_en;
  logic         par_typ;
  logic         tx_out;
  logic         busy;

  always #5 clk = ~clk;

  top_tx #(.DATA_LENGTH(W)) dut (
    .CLK        (clk),
    .RST        (rst),
    .P_DATA     (p_data),
    .DATA_VALID (data_valid),
    .PAR_EN     (par_en),
    .PAR_TYP    (par_typ),
    .TX_OUT     (tx_out),
    .BUSY       (busy)
  );

  typedef struct {
    logic tx;
    logic busy;
  } sample_t;

  typedef struct {
    string        name;
    logic [W-1:0] data;
    logic         valid;
    logic         pen;
    logic         ptyp;
    logic [10:0]  exp_tx;      // bit i = i-th sample after the accepting edge
    int           busy_cycles; // samples with BUSY expected high
  } vec_t;

  sample_t exp_q[$];
  vec_t    vecs[5];
  int      total  = 0;
  int      passed = 0;

  task automatic check(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end else begin
      passed++;
    end
  endtask

  // Reference frame: start, data LSB first, optional parity, stop, then idle high.
  function automatic logic [10:0] model_bits(input logic [W-1:0] d, input logic pen,
                                             input logic ptyp);
    logic [10:0] b;
    b = '1;
    b[0] = 1'b0;
    for (int k = 0; k < W; k++) b[1+k] = d[k];
    if (pen) b[9] = (^d) ^ ptyp;
    return b;
  endfunction

  // Queue the expected samples, then present the request for exactly one edge.
  task automatic send(input logic [W-1:0] d, input logic valid, input logic pen,
                      input logic ptyp, input logic [10:0] bits, input int busy_n);
    sample_t s;
    for (int i = 0; i < 11; i++) begin
      s.tx   = bits[i];
      s.busy = (i < busy_n);
      exp_q.push_back(s);
    end
    @(posedge clk);
    #1;
    p_data     = d;
    par_en     = pen;
    par_typ    = ptyp;
    data_valid = valid;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
  endtask

  // Pop and compare n samples; optionally scramble the inputs while the frame runs.
  task automatic capture(input int n, input bit disturb, input string tag);
    sample_t s;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL %s[%0d]: scoreboard empty, got tx=%b busy=%b", tag, i, tx_out, busy);
      end else begin
        s = exp_q.pop_front();
        check($sformatf("%s tx[%0d]", tag, i), tx_out, s.tx);
        check($sformatf("%s busy[%0d]", tag, i), busy, s.busy);
      end
      if (disturb) begin
        p_data     = W'($urandom);
        par_en     = 1'($urandom);
        par_typ    = 1'($urandom);
        data_valid = 1'($urandom);
      end
    end
    if (disturb) data_valid = 1'b0;
  endtask

  initial begin
    logic [W-1:0] d;
    logic [10:0]  bits;

    vecs[0] = '{"no_parity", 8'h7D, 1'b1, 1'b0, 1'b0, 11'b11011111010, 10};
    vecs[1] = '{"even_par",  8'hAD, 1'b1, 1'b1, 1'b0, 11'b11101011010, 11};
    vecs[2] = '{"odd_par57", 8'h57, 1'b1, 1'b1, 1'b1, 11'b10010101110, 11};
    vecs[3] = '{"odd_par59", 8'h59, 1'b1, 1'b1, 1'b1, 11'b11010110010, 11};
    vecs[4] = '{"no_req",    8'h3C, 1'b0, 1'b1, 1'b1, 11'b11111111111, 0};

    rst        = 1'b1;
    p_data     = '0;
    data_valid = 1'b0;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset tx_out", tx_out, 1'b1);
    check("reset busy", busy, 1'b0);
    rst = 1'b0;

    // Fixed vectors from the test plan
    for (int v = 0; v < 5; v++) begin
      send(vecs[v].data, vecs[v].valid, vecs[v].pen, vecs[v].ptyp,
           vecs[v].exp_tx, vecs[v].busy_cycles);
      capture(11, 1'b0, vecs[v].name);
      $display("vector %s data=%02h pen=%b ptyp=%b done", vecs[v].name, vecs[v].data,
               vecs[v].pen, vecs[v].ptyp);
    end

    // Back-to-back frames with a single idle cycle between them
    for (int f = 0; f < 100; f++) begin
      logic ptyp;
      ptyp = (f < 50) ? 1'b1 : 1'b0;
      d    = W'($urandom_range(0, 255));
      bits = model_bits(d, 1'b1, ptyp);
      send(d, 1'b1, 1'b1, ptyp, bits, 11);
      capture(11, 1'b0, $sformatf("rand%0d", f));
      $display("random frame %0d data=%02h ptyp=%b", f, d, ptyp);
    end

    // Inputs scrambled while a frame is in flight must not alter it
    d    = 8'hA5;
    bits = model_bits(d, 1'b1, 1'b0);
    send(d, 1'b1, 1'b1, 1'b0, bits, 11);
    capture(11, 1'b1, "disturb");
    $display("disturbed frame data=%02h", d);

    // Idle stays quiet after the disturbance
    @(posedge clk);
    @(negedge clk);
    check("post_disturb idle tx", tx_out, 1'b1);
    check("post_disturb idle busy", busy, 1'b0);

    // Reset while a 0 data bit is on the line
    d    = 8'hC3;
    bits = model_bits(d, 1'b1, 1'b0);
    send(d, 1'b1, 1'b1, 1'b0, bits, 11);
    capture(4, 1'b0, "pre_reset");
    #2;
    rst = 1'b1;
    #1;
    check("async reset tx_out", tx_out, 1'b1);
    check("async reset busy", busy, 1'b0);
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("held reset tx_out", tx_out, 1'b1);
    check("held reset busy", busy, 1'b0);
    rst = 1'b0;
    $display("mid-frame reset applied");

    d    = 8'h3A;
    bits = model_bits(d, 1'b1, 1'b1);
    send(d, 1'b1, 1'b1, 1'b1, bits, 11);
    capture(11, 1'b0, "post_reset");
    $display("post-reset frame data=%02h", d);

    total++;
    if (exp_q.size() != 0) begin
      $display("FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
    end else begin
      passed++;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/top_tx.md
# top_tx

UART-style serial transmitter with parameterised data width. It accepts a parallel word on a one-cycle `DATA_VALID` strobe and shifts out a frame on `TX_OUT`: start bit, data LSB-first, optional parity, stop bit. `BUSY` is high for the duration of the frame. It sits between a parallel producer and the serial line. Internally it is partitioned into a control FSM, serializer, parity generator and output mux.

## Interface
- `DATA_LENGTH`, default 8: data bits per frame (≥1).

Ports:
- `CLK`  in  1  single clock; all state updates on the rising edge.
- `RST`  in  1  reset, asynchronous, active-high.
- `P_DATA`  in  `DATA_LENGTH`  parallel word; captured when `DATA_VALID` is accepted.
- `DATA_VALID`  in  1  one-cycle request to send `P_DATA`.
- `PAR_EN`  in  1  1 = insert a parity bit; captured with the data.
- `PAR_TYP`  in  1  0 = even parity, 1 = odd parity; captured with the data.
- `TX_OUT`  out  1  serial line; idles high.
- `BUSY`  out  1  high while a frame is on the line.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- **IDLE.** `TX_OUT`=1, `BUSY`=0.
  - If `DATA_VALID`=1 at a rising edge, latch `P_DATA`, `PAR_EN` and `PAR_TYP`, then go to START.
- **START.** `TX_OUT`=0 for one cycle, then go to DATA.
- **DATA.** Drive latched bit 0 first, through bit `DATA_LENGTH`-1, one bit per cycle.
  - A bit counter of width ceil(log2(`DATA_LENGTH`)) controls this state.
  - After the last bit, go to PARITY if the latched `PAR_EN`=1, otherwise go to STOP.
- **PARITY.** One cycle.
  - Bit value = XOR-reduction of the latched data when `PAR_TYP`=0.
  - Bit value = its complement when `PAR_TYP`=1.
  - The total count of ones over data plus parity is therefore even or odd respectively.
- **STOP.** `TX_OUT`=1 for one cycle, then go to IDLE.
- `DATA_VALID` is ignored in every state except IDLE. Input changes during a frame do not affect that frame.
- `BUSY`=1 in START, DATA, PARITY and STOP.
- `TX_OUT` and `BUSY` are registered outputs (glitch-free).
- Reset (any time, including mid-frame): the frame is aborted immediately and the block returns to IDLE.
  - `TX_OUT`=1 and `BUSY`=0 asynchronously.
  - The latched data, the bit counter and the parity register are cleared.

## Timing
- Edge E0 is the rising edge that samples `DATA_VALID`=1 in IDLE.
  - The start bit is on `TX_OUT` from E0 to E1, and `BUSY` rises at E0.
  - Latency is one cycle.
- Data bit k is on the line from E(1+k) to E(2+k).
- With parity (`DATA_LENGTH`=8):
  - The parity bit is on the line from E9 to E10.
  - The stop bit is on the line from E10 to E11.
  - The block is back in IDLE at E11, with `BUSY`=0 at E11.
  - Frame length is `DATA_LENGTH`+3 cycles.
- Without parity, the stop bit is from E9 to E10 and IDLE begins at E10. Frame length is `DATA_LENGTH`+2 cycles.
- The next `DATA_VALID` may be sampled at the first edge after returning to IDLE. Frames separated by one idle cycle must both transmit correctly.
- `DATA_VALID` held high for several cycles starts only one frame. A new frame starts only if `DATA_VALID` is still high at an edge in IDLE.

## Test plan
In every scenario, `TX_OUT` is sampled once per cycle for 11 cycles starting one cycle after `DATA_VALID`, and the sequence is given in send order.

- **No parity.** `P_DATA`=0x7D, `PAR_EN`=0. Required: 0,1,0,1,1,1,1,1,0,1,1.
  - This is start, LSB-first data, stop, then idle.
  - `BUSY` is high for 10 cycles.
- **Even parity.** `P_DATA`=0xAD, `PAR_EN`=1, `PAR_TYP`=0. Required: 0,1,0,1,1,0,1,0,1,1,1.
  - The parity bit is 1 (five ones in the data).
- **Odd parity.** `P_DATA`=0x57, `PAR_TYP`=1. Required: parity bit 0, stop bit 1.
  - Also `P_DATA`=0x59, `PAR_TYP`=1. Required: parity bit 1.
- **No request.** `DATA_VALID` held 0 with arbitrary inputs. Required: `TX_OUT`=1 and `BUSY`=0 for all 11 cycles.
- **Randomized run.** 50 random words with odd parity, then 50 with even parity, each separated by one idle cycle.
  - Each frame must equal {1, parity, data, 0}, listed from the last bit sent to the first bit sent.
- **Robustness.**
  - Toggle `P_DATA`, `PAR_EN` and `DATA_VALID` mid-frame. Required: the frame is unchanged.
  - Assert `RST` mid-DATA. Required: `TX_OUT`=1 and `BUSY`=0 immediately, and the next request transmits a correct full frame.
